// File: rtl/clock_divider_bank.sv
// Bank of independent registered clock dividers sharing one lock indicator.
// Each channel starts, stops and retunes only at period boundaries.
module clock_divider_bank #(
  parameter int CHANNELS    = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int RST_PERIODS = 2
) (
  input  logic                          i_refclk,
  input  logic                          i_rst,
  input  logic [CHANNELS-1:0]           i_en,
  input  logic [CHANNELS*DIV_WIDTH-1:0] i_div,
  output logic [CHANNELS-1:0]           o_outclk,
  output logic [CHANNELS-1:0]           o_stb,
  output logic [CHANNELS-1:0]           o_rst_out,
  output logic                          o_locked
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int SW = $clog2(RST_PERIODS + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);

  logic [LW-1:0] r_lockCnt;
  logic          r_locked;
  logic          w_lockNow;

  // True on the edge where locked sets as well, so a waiting channel starts with it.
  assign w_lockNow = r_locked | (r_lockCnt == LW'(LOCK_CYCLES - 1));

  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_lockCnt <= '0;
      r_locked  <= 1'b0;
    end else if (!r_locked) begin
      r_lockCnt <= r_lockCnt + LW'(1);
      r_locked  <= w_lockNow;
    end
  end

  assign o_locked = r_locked;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [0:0]           r_state;
    logic [0:0]           w_stateNext;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] w_cntNext;
    logic [DIV_WIDTH-1:0] r_dAct;
    logic [DIV_WIDTH-1:0] w_dActNext;
    logic [DIV_WIDTH-1:0] w_divRaw;
    logic [DIV_WIDTH-1:0] w_divClamp;
    logic [SW-1:0]        r_stbCnt;
    logic [SW-1:0]        w_stbCntNext;
    logic [DIV_WIDTH:0]   w_half;
    logic                 w_wrap;
    logic                 w_stbNext;
    logic                 w_rstOutNext;
    logic                 w_outNext;
    logic                 r_outclk;
    logic                 r_stb;
    logic                 r_rstOut;

    assign w_divRaw   = i_div[g*DIV_WIDTH +: DIV_WIDTH];
    assign w_divClamp = (w_divRaw < TWO) ? TWO : w_divRaw;
    assign w_wrap     = (r_cnt == r_dAct - ONE);

    always_comb begin
      w_stateNext  = r_state;
      w_cntNext    = r_cnt;
      w_dActNext   = r_dAct;
      w_stbCntNext = r_stbCnt;
      w_stbNext    = 1'b0;
      w_rstOutNext = r_rstOut;
      case (r_state)
        S_IDLE: begin
          w_cntNext    = '0;
          w_dActNext   = w_divClamp;
          w_rstOutNext = 1'b1;
          if (w_lockNow && i_en[g]) begin
            w_stateNext  = S_RUN;
            w_stbNext    = 1'b1;
            w_stbCntNext = SW'(1);
          end
        end
        default: begin
          if (!w_wrap) begin
            w_cntNext = r_cnt + ONE;
          end else if (i_en[g]) begin
            w_cntNext  = '0;
            w_dActNext = w_divClamp;
            w_stbNext  = 1'b1;
            // Reaching the saturated count means this strobe ends the reset window.
            if (r_stbCnt == SW'(RST_PERIODS)) begin
              w_rstOutNext = 1'b0;
            end else begin
              w_stbCntNext = r_stbCnt + SW'(1);
            end
          end else begin
            w_stateNext  = S_IDLE;
            w_cntNext    = '0;
            w_dActNext   = w_divClamp;
            w_stbCntNext = '0;
            w_rstOutNext = 1'b1;
          end
        end
      endcase
      w_half    = ({1'b0, w_dActNext} + (DIV_WIDTH+1)'(1)) >> 1;
      w_outNext = (w_stateNext == S_RUN) && ({1'b0, w_cntNext} < w_half);
    end

    always_ff @(posedge i_refclk or posedge i_rst) begin
      if (i_rst) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_dAct   <= TWO;
        r_stbCnt <= '0;
        r_outclk <= 1'b0;
        r_stb    <= 1'b0;
        r_rstOut <= 1'b1;
      end else begin
        r_state  <= w_stateNext;
        r_cnt    <= w_cntNext;
        r_dAct   <= w_dActNext;
        r_stbCnt <= w_stbCntNext;
        r_outclk <= w_outNext;
        r_stb    <= w_stbNext;
        r_rstOut <= w_rstOutNext;
      end
    end

    assign o_outclk[g]  = r_outclk;
    assign o_stb[g]     = r_stb;
    assign o_rst_out[g] = r_rstOut;
  end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Parametrised clock generation block for the board tops. It derives up to CHANNELS glitch-free, registered divided clocks from one reference clock. Each channel has a run-time divisor, a coincident enable strobe and a sequenced per-channel synchronous reset. A global `locked` indicator asserts after a fixed settle time, and a channel starts, stops and changes ratio only on period boundaries. It sits between the board clock input and the SoC, alongside the buffer/forwarding primitives.

## Interface
- CHANNELS, 2, number of independent output channels (≥1)
- DIV_WIDTH, 8, width of each divisor field
- LOCK_CYCLES, 16, refclk cycles from reset release to `locked`=1 (≥1)
- RST_PERIODS, 2, full output periods a channel's `rst_out` stays high after the channel starts (≥1)

Ports:
- refclk  in  1  reference clock; all flops on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  CHANNELS  per-channel run request
- div  in  CHANNELS*DIV_WIDTH  divisor of channel i in bits [i*DIV_WIDTH +: DIV_WIDTH]
- outclk  out  CHANNELS  divided clock, driven directly from a flop
- stb  out  CHANNELS  one-cycle pulse coinciding with each outclk rising edge
- rst_out  out  CHANNELS  per-channel synchronous reset, active-high
- locked  out  1  settle time elapsed

## Operation
- Effective divisor: d = max(div_i, 2); 0 and 1 clamp to 2.
- Lock counter:
  - Counts refclk edges after `rst` release.
  - `locked` sets on the LOCK_CYCLES-th edge and stays 1 until `rst`.
- Per-channel state: IDLE / RUN, counter cnt (DIV_WIDTH bits), active divisor d_act, strobe counter (saturates at RST_PERIODS).
- IDLE:
  - cnt=0, outclk=0, stb=0, rst_out=1.
  - d_act reloads the clamped div_i every cycle.
- IDLE→RUN:
  - Condition: an edge with `locked`=1 and en_i=1 (including the edge on which `locked` sets).
  - On that edge: cnt=0, outclk=1, stb=1, strobe count=1.
- RUN, cnt < d_act-1: cnt+1.
- RUN, cnt = d_act-1 (wrap):
  - If en_i=1: cnt=0, d_act loads the clamped div_i, outclk=1, stb=1, strobe count +1.
  - If en_i=0: go IDLE.
- Waveform invariant in RUN: outclk_i == (cnt < ceil(d_act/2)), so the high phase is ceil(d/2) cycles and the low phase is floor(d/2) cycles. outclk is computed from next-state values and registered; it is never decoded combinationally.
- stb_i == (RUN and cnt==0), also registered.
- Divisor changes mid-period never shorten or lengthen the current period. The new value applies from the next period start.
- en_i deassert mid-period: the current period completes in full, so there is no runt pulse. Re-asserting en_i before the wrap cancels the stop.
- rst_out_i:
  - Falls on the edge that issues the (RST_PERIODS+1)-th strobe, i.e. it is held for RST_PERIODS full periods.
  - Rises on the edge entering IDLE.
- Channels are fully independent; CHANNELS counters share only `locked`.

## Timing
- Reset values (asynchronous, immediate, no clock needed): outclk=0, stb=0, rst_out=all 1, locked=0, all channels IDLE, lock counter 0.
- Reset asserted mid-run: every output takes its reset value at once. The lock sequence restarts on release, with LOCK_CYCLES edges until `locked`.
- Latency en_i rise → first outclk high:
  - 1 edge when `locked`=1.
  - Otherwise the edge on which `locked` sets.
- Latency en_i fall → IDLE: at the end of the current period, between 1 and d_act edges.
- Simultaneous wrap and en_i=0 with div change: the channel goes IDLE. d_act then tracks div while IDLE.
- Output clock frequency is f_refclk/d. Maximum d = 2^DIV_WIDTH-1.

## Test plan
1. CHANNELS=2, LOCK_CYCLES=16, RST_PERIODS=2. Release rst with en0=1, div0=4 → `locked` rises on edge 16. outclk0 reads 1,1,0,0 repeating from that edge; stb0 pulses every 4 cycles; channel 1 (en1=0) stays outclk=0, rst_out=1.
2. div0=5 → outclk0 reads 1,1,1,0,0. div1=0 and div1=1 each → outclk1 reads 1,0 (clamped to 2). Both channels run concurrently and unaffected by each other.
3. div0 changes 4→6 while cnt=1 → current period is 4 cycles (1,1,0,0), then 1,1,1,0,0,0. The stb spacing goes from 4 to 6.
4. en0 falls at cnt=1, d=4 → outclk0 0,0 for cnt 2,3, then IDLE with outclk0=0 and rst_out0=1 on the wrap edge. en0 re-raised at cnt=2 instead → running continues uninterrupted.
5. Start with d=4 → rst_out0 falls on the edge of the third strobe, 8 cycles after the first.
6. Assert rst asynchronously mid-high-phase → outclk, stb and locked go 0 and rst_out goes 1 before the next refclk edge. After release, the full 16-cycle lock sequence repeats.
